// File: rtl/rv_pipe_ctrl.sv
// Pipeline stall/flush controller for a 5-stage RISC-V core: boot hold, freeze, redirect, load-use and fetch-wait.
// Optional performance counters are built only when RV_PIPE_CTRL_PERF_EN is defined.
module rv_pipe_ctrl #(
  parameter int BOOT_CYC     = 4,
  parameter int DMEM_TIMEOUT = 255,
  parameter int BW_CNT       = 32
) (
  input  logic              i_pipe_ctrl_clk,
  input  logic              i_pipe_ctrl_rstn,
  input  logic [4:0]        i_pipe_ctrl_id_rs1,
  input  logic [4:0]        i_pipe_ctrl_id_rs2,
  input  logic [4:0]        i_pipe_ctrl_ex_rd,
  input  logic              i_pipe_ctrl_ex_memrd,
  input  logic              i_pipe_ctrl_ex_br_taken,
  input  logic              i_pipe_ctrl_imem_ready,
  input  logic              i_pipe_ctrl_dmem_req,
  input  logic              i_pipe_ctrl_dmem_ready,
  output logic              o_pipe_ctrl_en_if,
  output logic              o_pipe_ctrl_en_id,
  output logic              o_pipe_ctrl_en_ex,
  output logic              o_pipe_ctrl_en_mem,
  output logic              o_pipe_ctrl_en_wb,
  output logic              o_pipe_ctrl_flush_id,
  output logic              o_pipe_ctrl_flush_ex,
  output logic              o_pipe_ctrl_err,
  output logic [BW_CNT-1:0] o_pipe_ctrl_stall_cnt,
  output logic [BW_CNT-1:0] o_pipe_ctrl_flush_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, ERR} state_t;

  localparam logic [7:0] BOOT_LAST    = 8'(BOOT_CYC - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(DMEM_TIMEOUT - 1);
  localparam bit         TIMEOUT_ON   = (DMEM_TIMEOUT != 0);

  state_t     state;
  state_t     state_next;
  logic [7:0] boot_cnt;
  logic [7:0] wait_cnt;
  logic       freeze;
  logic       load_use;
  logic       timeout_hit;
  logic [4:0] en_vec;
  logic       flush_id;
  logic       flush_ex;

  assign freeze   = i_pipe_ctrl_dmem_req && !i_pipe_ctrl_dmem_ready;
  assign load_use = i_pipe_ctrl_ex_memrd && (i_pipe_ctrl_ex_rd != 5'd0) &&
                    ((i_pipe_ctrl_ex_rd == i_pipe_ctrl_id_rs1) ||
                     (i_pipe_ctrl_ex_rd == i_pipe_ctrl_id_rs2));
  // The cycle that would make the wait count equal DMEM_TIMEOUT is the last one tolerated.
  assign timeout_hit = TIMEOUT_ON && freeze && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge i_pipe_ctrl_clk or negedge i_pipe_ctrl_rstn) begin
    if (!i_pipe_ctrl_rstn) begin
      state    <= BOOT;
      boot_cnt <= 8'd0;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      boot_cnt <= (state == BOOT) ? boot_cnt + 8'd1 : 8'd0;
      if ((state == RUN) && freeze)
        wait_cnt <= (&wait_cnt) ? wait_cnt : wait_cnt + 8'd1;
      else
        wait_cnt <= 8'd0;
    end
  end

  // en_vec bit order is {if, id, ex, mem, wb}; BOOT and ERR share the hold-and-bubble pattern.
  always_comb begin
    state_next = state;
    en_vec     = 5'b00000;
    flush_id   = 1'b1;
    flush_ex   = 1'b1;
    case (state)
      BOOT: begin
        if (boot_cnt == BOOT_LAST)
          state_next = RUN;
      end
      RUN: begin
        if (freeze) begin
          en_vec   = 5'b00000;
          flush_id = 1'b0;
          flush_ex = 1'b0;
          if (timeout_hit)
            state_next = ERR;
        end else if (i_pipe_ctrl_ex_br_taken) begin
          en_vec   = 5'b11111;
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (load_use) begin
          en_vec   = 5'b00111;
          flush_id = 1'b0;
          flush_ex = 1'b1;
        end else if (!i_pipe_ctrl_imem_ready) begin
          en_vec   = 5'b01111;
          flush_id = 1'b1;
          flush_ex = 1'b0;
        end else begin
          en_vec   = 5'b11111;
          flush_id = 1'b0;
          flush_ex = 1'b0;
        end
      end
      ERR: begin
        state_next = ERR;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  assign o_pipe_ctrl_en_if    = en_vec[4];
  assign o_pipe_ctrl_en_id    = en_vec[3];
  assign o_pipe_ctrl_en_ex    = en_vec[2];
  assign o_pipe_ctrl_en_mem   = en_vec[1];
  assign o_pipe_ctrl_en_wb    = en_vec[0];
  assign o_pipe_ctrl_flush_id = flush_id;
  assign o_pipe_ctrl_flush_ex = flush_ex;
  assign o_pipe_ctrl_err      = (state == ERR);

`ifdef RV_PIPE_CTRL_PERF_EN
  logic              stall_evt;
  logic              flush_evt;
  logic [BW_CNT-1:0] stall_cnt;
  logic [BW_CNT-1:0] flush_cnt;

  assign stall_evt = (state == RUN) && !en_vec[4];
  assign flush_evt = (state == RUN) && (flush_id || flush_ex);

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge i_pipe_ctrl_clk or negedge i_pipe_ctrl_rstn) begin
    if (!i_pipe_ctrl_rstn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && !(&flush_cnt))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign o_pipe_ctrl_stall_cnt = stall_cnt;
  assign o_pipe_ctrl_flush_cnt = flush_cnt;
`else
  assign o_pipe_ctrl_stall_cnt = '0;
  assign o_pipe_ctrl_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Table-driven, scoreboarded bench for rv_pipe_ctrl (BOOT_CYC=4, DMEM_TIMEOUT=8, 4-bit counters).
module tb_rv_pipe_ctrl;

  localparam int BW = 4;
`ifdef RV_PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    rs1, rs2, ex_rd;
  logic          ex_memrd, ex_br_taken, imem_ready, dmem_req, dmem_ready;
  logic          en_if, en_id, en_ex, en_mem, en_wb, flush_id, flush_ex, err;
  logic [BW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  rv_pipe_ctrl #(.BOOT_CYC(4), .DMEM_TIMEOUT(8), .BW_CNT(BW)) dut (
    .i_pipe_ctrl_clk         (clk),
    .i_pipe_ctrl_rstn        (rst_n),
    .i_pipe_ctrl_id_rs1      (rs1),
    .i_pipe_ctrl_id_rs2      (rs2),
    .i_pipe_ctrl_ex_rd       (ex_rd),
    .i_pipe_ctrl_ex_memrd    (ex_memrd),
    .i_pipe_ctrl_ex_br_taken (ex_br_taken),
    .i_pipe_ctrl_imem_ready  (imem_ready),
    .i_pipe_ctrl_dmem_req    (dmem_req),
    .i_pipe_ctrl_dmem_ready  (dmem_ready),
    .o_pipe_ctrl_en_if       (en_if),
    .o_pipe_ctrl_en_id       (en_id),
    .o_pipe_ctrl_en_ex       (en_ex),
    .o_pipe_ctrl_en_mem      (en_mem),
    .o_pipe_ctrl_en_wb       (en_wb),
    .o_pipe_ctrl_flush_id    (flush_id),
    .o_pipe_ctrl_flush_ex    (flush_ex),
    .o_pipe_ctrl_err         (err),
    .o_pipe_ctrl_stall_cnt   (stall_cnt),
    .o_pipe_ctrl_flush_cnt   (flush_cnt)
  );

  typedef struct {
    string      tag;
    logic [4:0] rs1, rs2, rd;
    logic       memrd, br, imem, dreq, drdy;
    logic       run;
    logic [4:0] en;
    logic       fid, fex, err;
  } vec_t;

  typedef struct {
    string         tag;
    logic [7:0]    outs;
    logic [BW-1:0] stall, flush;
  } exp_t;

  exp_t          sb[$];
  int            n_vec  = 0;
  int            n_miss = 0;
  logic [BW-1:0] m_stall = '0;
  logic [BW-1:0] m_flush = '0;
  vec_t          tbl[14];

  function automatic vec_t mkv(input string tag, input logic [4:0] r1, r2, rd,
                               input logic memrd, br, imem, dreq, drdy, run,
                               input logic [4:0] en, input logic fid, fex, e);
    vec_t v;
    v.tag = tag; v.rs1 = r1; v.rs2 = r2; v.rd = rd;
    v.memrd = memrd; v.br = br; v.imem = imem; v.dreq = dreq; v.drdy = drdy;
    v.run = run; v.en = en; v.fid = fid; v.fex = fex; v.err = e;
    return v;
  endfunction

  function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  task automatic drive(input vec_t v);
    rs1 = v.rs1; rs2 = v.rs2; ex_rd = v.rd; ex_memrd = v.memrd; ex_br_taken = v.br;
    imem_ready = v.imem; dmem_req = v.dreq; dmem_ready = v.drdy;
  endtask

  // Counters are registered, so the expectation for this cycle is the model before this cycle's event.
  task automatic push_expected(input vec_t v);
    exp_t e;
    e.tag  = v.tag;
    e.outs = {v.en, v.fid, v.fex, v.err};
    e.stall = PERF ? m_stall : '0;
    e.flush = PERF ? m_flush : '0;
    if (v.run) begin
      if (!v.en[4])        m_stall = sat_inc(m_stall);
      if (v.fid || v.fex)  m_flush = sat_inc(m_flush);
    end
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t       e;
    logic [7:0] act;
    if (sb.size() == 0) begin
      n_vec++; n_miss++;
      $display("[TB] FAIL scoreboard_empty at %0t", $time);
      return;
    end
    e   = sb.pop_front();
    act = {en_if, en_id, en_ex, en_mem, en_wb, flush_id, flush_ex, err};
    n_vec++;
    if (act !== e.outs) begin
      n_miss++;
      $display("[TB] FAIL %s outs{en5,fid,fex,err} got %b want %b at %0t", e.tag, act, e.outs, $time);
    end
    if (stall_cnt !== e.stall) begin
      n_miss++;
      $display("[TB] FAIL %s stall_cnt got %0d want %0d", e.tag, stall_cnt, e.stall);
    end
    if (flush_cnt !== e.flush) begin
      n_miss++;
      $display("[TB] FAIL %s flush_cnt got %0d want %0d", e.tag, flush_cnt, e.flush);
    end
  endtask

  task automatic check_value(input string name, input logic [BW-1:0] act, input logic [BW-1:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("[TB] FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    drive(v);
    push_expected(v);
    @(negedge clk);
    check_output();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect, then walks through the boot window.
  task automatic do_reset(input string tag);
    vec_t b;
    rst_n = 1'b0;
    #2;
    m_stall = '0;
    m_flush = '0;
    push_expected(mkv({tag, "_in_reset"}, 0,0,0, 0,0,1,0,0, 0, 5'b00000, 1,1,0));
    check_output();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    b = mkv({tag, "_boot"}, 5,5,5, 1,1,0,0,0, 0, 5'b00000, 1,1,0);
    for (int i = 0; i < 4; i++) apply_stimulus(b);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t nrm, fw, rd_, frz, frz_br, rdy_br;
    rst_n = 1'b0;
    drive(mkv("idle", 0,0,0, 0,0,1,0,0, 0, 5'b0, 0,0,0));

    //                tag          rs1 rs2 rd mrd br imem dreq drdy run en        fid fex err
    tbl[0]  = mkv("normal",       1, 2, 3, 0, 0, 1, 0, 0, 1, 5'b11111, 0, 0, 0);
    tbl[1]  = mkv("lu_rs2",       3, 5, 5, 1, 0, 1, 0, 0, 1, 5'b00111, 0, 1, 0);
    tbl[2]  = mkv("lu_rd0",       3, 5, 0, 1, 0, 1, 0, 0, 1, 5'b11111, 0, 0, 0);
    tbl[3]  = mkv("lu_x0_src",    0, 0, 0, 1, 0, 1, 0, 0, 1, 5'b11111, 0, 0, 0);
    tbl[4]  = mkv("lu_rs1",       7, 9, 7, 1, 0, 1, 0, 0, 1, 5'b00111, 0, 1, 0);
    tbl[5]  = mkv("no_load",      3, 5, 5, 0, 0, 1, 0, 0, 1, 5'b11111, 0, 0, 0);
    tbl[6]  = mkv("br_over_lu",   3, 5, 5, 1, 1, 1, 0, 0, 1, 5'b11111, 1, 1, 0);
    tbl[7]  = mkv("fetch_wait",   1, 2, 3, 0, 0, 0, 0, 0, 1, 5'b01111, 1, 0, 0);
    tbl[8]  = mkv("lu_over_fw",   5, 2, 5, 1, 0, 0, 0, 0, 1, 5'b00111, 0, 1, 0);
    tbl[9]  = mkv("freeze",       1, 2, 3, 0, 0, 1, 1, 0, 1, 5'b00000, 0, 0, 0);
    tbl[10] = mkv("dmem_done",    1, 2, 3, 0, 0, 1, 1, 1, 1, 5'b11111, 0, 0, 0);
    tbl[11] = mkv("ready_noreq",  1, 2, 3, 0, 0, 1, 0, 1, 1, 5'b11111, 0, 0, 0);
    tbl[12] = mkv("frz_over_all", 5, 5, 5, 1, 1, 0, 1, 0, 1, 5'b00000, 0, 0, 0);
    tbl[13] = mkv("br_over_fw",   1, 2, 3, 0, 1, 0, 0, 0, 1, 5'b11111, 1, 1, 0);

    nrm    = tbl[0];
    fw     = tbl[7];
    frz    = tbl[9];
    rdy_br = mkv("redirect",  1, 2, 3, 0, 1, 1, 1, 1, 1, 5'b11111, 1, 1, 0);
    frz_br = mkv("frz_br",    1, 2, 3, 0, 1, 1, 1, 0, 1, 5'b00000, 0, 0, 0);
    rd_    = mkv("err_hold",  5, 5, 5, 1, 1, 0, 0, 0, 0, 5'b00000, 1, 1, 1);

    #1;
    do_reset("por");
    apply_stimulus(nrm);

    for (int i = 0; i < 14; i++) apply_stimulus(tbl[i]);

    // Branch held through a 3-cycle freeze takes effect only once memory completes.
    for (int i = 0; i < 3; i++) apply_stimulus(frz_br);
    apply_stimulus(rdy_br);

    // Seven waits then completion on what would be the timeout cycle: no error.
    for (int i = 0; i < 7; i++) apply_stimulus(frz);
    apply_stimulus(tbl[10]);
    apply_stimulus(nrm);

    apply_stimulus(frz);
    apply_stimulus(frz);
    drive(frz);
    do_reset("mid_freeze");
    apply_stimulus(nrm);

    apply_stimulus(fw);
    apply_stimulus(fw);
    apply_stimulus(tbl[13]);
    check_value("stall_cnt_after_2fw_1br", stall_cnt, PERF ? 4'd2 : 4'd0);
    check_value("flush_cnt_after_2fw_1br", flush_cnt, PERF ? 4'd3 : 4'd0);
    apply_stimulus(nrm);
    for (int i = 0; i < 16; i++) apply_stimulus(fw);
    apply_stimulus(nrm);
    check_value("stall_cnt_saturated", stall_cnt, PERF ? 4'd15 : 4'd0);

    for (int i = 0; i < 8; i++) apply_stimulus(frz);
    for (int i = 0; i < 3; i++) apply_stimulus(rd_);
    apply_stimulus(mkv("err_idle", 1, 2, 3, 0, 0, 1, 0, 0, 0, 5'b00000, 1, 1, 1));
    drive(nrm);
    do_reset("from_err");
    apply_stimulus(nrm);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rv_pipe_ctrl.md
RV_PIPE_CTRL -- requirements
Module: rv_pipe_ctrl

Interface
REQ-001 Parameter BOOT_CYC, default 4: post-reset cycles with all pipeline registers held (range 1..255).
REQ-002 Parameter DMEM_TIMEOUT, default 255: consecutive data-memory wait cycles before error; 0 disables the timeout.
REQ-003 Parameter BW_CNT, default 32: width of the performance counters.
REQ-004 i_pipe_ctrl_clk  in  1  clock, rising edge.
REQ-005 i_pipe_ctrl_rstn  in  1  reset, asynchronous, active-low.
REQ-006 i_pipe_ctrl_id_rs1, i_pipe_ctrl_id_rs2  in  5 each  source registers of the instruction in ID.
REQ-007 i_pipe_ctrl_ex_rd  in  5  destination register of the instruction in EX.
REQ-008 i_pipe_ctrl_ex_memrd  in  1  instruction in EX is a load.
REQ-009 i_pipe_ctrl_ex_br_taken  in  1  branch or jump in EX redirects the PC.
REQ-010 i_pipe_ctrl_imem_ready  in  1  instruction fetch data is valid this cycle.
REQ-011 i_pipe_ctrl_dmem_req, i_pipe_ctrl_dmem_ready  in  1 each  data-memory access pending in MEM, and its completion.
REQ-012 o_pipe_ctrl_en_if, _en_id, _en_ex, _en_mem, _en_wb  out  1 each  enables for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
REQ-013 o_pipe_ctrl_flush_id, o_pipe_ctrl_flush_ex  out  1 each  load a bubble into IF/ID or ID/EX; flush overrides enable at the register.
REQ-014 o_pipe_ctrl_err  out  1  sticky data-memory timeout flag.
REQ-015 o_pipe_ctrl_stall_cnt, o_pipe_ctrl_flush_cnt  out  BW_CNT each  performance counters.

Function
REQ-016 FSM states: BOOT, RUN, ERR; the state and all counters are registered, and the enable and flush outputs are combinational from the state and inputs.
REQ-017 BOOT: all en_* = 0, flush_id = flush_ex = 1; the boot counter increments each cycle, and after BOOT_CYC cycles the FSM moves to RUN.
REQ-018 In RUN, conditions are evaluated in priority order (REQ-019..REQ-023); the first match sets the outputs.
REQ-019 Freeze (dmem_req=1 and dmem_ready=0): all en_* = 0 and both flushes = 0, so a pending branch or hazard is re-evaluated after the freeze.
REQ-020 Redirect (ex_br_taken=1): all en_* = 1, flush_id = 1, flush_ex = 1.
REQ-021 Load-use (ex_memrd=1, ex_rd≠0, and ex_rd==rs1 or ex_rd==rs2): en_if = en_id = 0, en_ex = en_mem = en_wb = 1, flush_ex = 1, flush_id = 0.
REQ-022 Fetch wait (imem_ready=0): en_if = 0, en_id = 1 with flush_id = 1, en_ex/en_mem/en_wb = 1, flush_ex = 0.
REQ-023 Otherwise: all en_* = 1 and both flushes = 0.
REQ-024 Wait counter: increments in each RUN freeze cycle and clears in any other cycle.
REQ-025 When DMEM_TIMEOUT≠0 and the counter reaches DMEM_TIMEOUT in a freeze cycle, the next state is ERR; if dmem_ready=1 in that same cycle, no freeze occurs and the FSM stays in RUN.
REQ-026 ERR: outputs as in BOOT and err = 1; ERR is left only by reset.
REQ-027 Source register x0 never creates a load-use hazard.

Reset
REQ-028 Reset assertion asynchronously forces BOOT, clears the boot and wait counters, sets err = 0 and clears the perf counters.
REQ-029 During reset, all en_* = 0 and both flushes = 1, including when reset asserts mid-freeze or in ERR.
REQ-030 On reset release, exactly BOOT_CYC BOOT cycles precede the first RUN cycle.

Configuration
REQ-031 The macro RV_PIPE_CTRL_PERF_EN selects whether the performance counters are built.
REQ-032 With RV_PIPE_CTRL_PERF_EN defined:
- stall_cnt increments once per RUN cycle in which en_if=0;
- flush_cnt increments once per RUN cycle in which flush_id or flush_ex is 1;
- both counters saturate at all-ones.
REQ-033 Without RV_PIPE_CTRL_PERF_EN: the ports remain present, are driven constant 0, and no counter flops exist.

Verification
REQ-034 Reset release with BOOT_CYC=4 -> outputs hold the BOOT values for 4 cycles, and all en_*=1 in cycle 5 with no hazards.
REQ-035 ex_memrd=1, ex_rd=5, rs2=5 for 1 cycle -> en_if=en_id=0 and flush_ex=1 for that cycle; the same stimulus with ex_rd=0 -> no stall.
REQ-036 ex_br_taken=1 together with a load-use hazard -> flush_id=flush_ex=1 and en_if=1; redirect wins.
REQ-037 dmem_req=1, dmem_ready=0 for 3 cycles, then ready=1, with ex_br_taken=1 throughout -> 3 cycles with all en_*=0 and flush=0, then the redirect outputs appear.
REQ-038 DMEM_TIMEOUT=8 with ready held at 0 -> err=1 from the 9th cycle, outputs stay in the BOOT pattern, and only rstn low clears err.
REQ-039 With PERF_EN: 2 fetch-wait cycles plus 1 redirect -> stall_cnt=2, flush_cnt=3; without PERF_EN -> both counters read 0.
